truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 136 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: built-in self-check sequencer for one minimized
// logic block. It sweeps every input vector, waits SETTLE_CYCLES per
// vector, and compares the block output against a golden truth table.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   start, abort      begin a sweep (IDLE only) / cancel a running sweep
//   dut_in, dut_out   vector driven to the block / its output F
//   busy, done        sweep running / one-cycle completion pulse
//   pass              last completed sweep had no mismatches
//   mismatch_count    number of mismatching vectors
//   first_fail_idx    lowest mismatching vector, valid when
//   first_fail_valid  is set
module truth_table_sweeper #(
    parameter int                          N_INPUTS      = 5,
    parameter logic [(1<<N_INPUTS)-1:0]    GOLDEN        = '0,
    parameter int                          SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   mismatch_count,
    output logic [N_INPUTS-1:0] first_fail_idx,
    output logic                first_fail_valid
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW = N_INPUTS + 1;
    localparam logic [SW-1:0]       SLAST   = SW'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] IDX_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [N_INPUTS-1:0] r_idx;
    logic [SW-1:0]       r_settle;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [CW-1:0]       r_mcnt;
    logic [N_INPUTS-1:0] r_ffi;
    logic                r_ffv;

    logic w_miss;

    // The vector index doubles as the driven input vector.
    assign dut_in           = r_idx;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign mismatch_count   = r_mcnt;
    assign first_fail_idx   = r_ffi;
    assign first_fail_valid = r_ffv;

    assign w_miss = dut_out ^ GOLDEN[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_mcnt   <= '0;
            r_ffi    <= '0;
            r_ffv    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_idx    <= '0;
                        r_settle <= '0;
                        r_busy   <= 1'b1;
                        r_pass   <= 1'b0;
                        r_mcnt   <= '0;
                        r_ffi    <= '0;
                        r_ffv    <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state  <= IDLE;
                        r_idx    <= '0;
                        r_settle <= '0;
                        r_busy   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_mcnt   <= '0;
                        r_ffi    <= '0;
                        r_ffv    <= 1'b0;
                    end else if (r_settle < SLAST) begin
                        r_settle <= r_settle + SW'(1);
                    end else begin
                        if (w_miss) begin
                            r_mcnt <= r_mcnt + CW'(1);
                            if (!r_ffv) begin
                                r_ffi <= r_idx;
                                r_ffv <= 1'b1;
                            end
                        end
                        if (r_idx == IDX_MAX) begin
                            // Final vector: pass must include this sample.
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_mcnt == '0) && !w_miss;
                        end else begin
                            r_idx    <= r_idx + N_INPUTS'(1);
                            r_settle <= '0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: three instances cover a
// patterned golden table (S=1), an all-ones table (S=1) and S=3.
module tb_truth_table_sweeper;

    localparam logic [31:0] G_A = 32'hA5C3_1E97;
    localparam logic [31:0] G_B = 32'hFFFF_FFFF;
    localparam logic [31:0] G_C = 32'h3C5A_96E1;

    logic       clk;
    logic       rst;
    logic       st   [3];
    logic       ab   [3];
    logic [4:0] din  [3];
    logic       dout [3];
    logic       bsy  [3];
    logic       dn   [3];
    logic       ps   [3];
    logic [5:0] mc   [3];
    logic [4:0] ffi  [3];
    logic       ffv  [3];
    logic       flip;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block models: A optionally inverts F at 7 and 20, B is stuck at 0.
    always_comb begin
        dout[0] = G_A[din[0]] ^ (flip && (din[0] == 5'd7 || din[0] == 5'd20));
        dout[1] = 1'b0;
        dout[2] = G_C[din[2]];
    end

    truth_table_sweeper #(.N_INPUTS(5), .GOLDEN(G_A), .SETTLE_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]),
        .dut_in(din[0]), .dut_out(dout[0]), .busy(bsy[0]), .done(dn[0]),
        .pass(ps[0]), .mismatch_count(mc[0]), .first_fail_idx(ffi[0]),
        .first_fail_valid(ffv[0])
    );

    truth_table_sweeper #(.N_INPUTS(5), .GOLDEN(G_B), .SETTLE_CYCLES(1)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]),
        .dut_in(din[1]), .dut_out(dout[1]), .busy(bsy[1]), .done(dn[1]),
        .pass(ps[1]), .mismatch_count(mc[1]), .first_fail_idx(ffi[1]),
        .first_fail_valid(ffv[1])
    );

    truth_table_sweeper #(.N_INPUTS(5), .GOLDEN(G_C), .SETTLE_CYCLES(3)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .abort(ab[2]),
        .dut_in(din[2]), .dut_out(dout[2]), .busy(bsy[2]), .done(dn[2]),
        .pass(ps[2]), .mismatch_count(mc[2]), .first_fail_idx(ffi[2]),
        .first_fail_valid(ffv[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_res(input int i, input logic p, input logic [5:0] m,
                           input logic [4:0] f, input logic v);
        chk("pass", 32'(ps[i]), 32'(p));
        chk("mcnt", 32'(mc[i]), 32'(m));
        chk("ffi", 32'(ffi[i]), 32'(f));
        chk("ffv", 32'(ffv[i]), 32'(v));
    endtask

    // Pulse start at edge 0, then follow every cycle until done drops.
    task automatic sweep(input int s, input int i, input bit hammer);
        int last;
        last = 32 * s + 1;
        @(negedge clk);
        st[i] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            st[i] = hammer && (c < last);
            if (c < last) begin
                chk("din", 32'(din[i]), 32'((c - 1) / s));
                chk("busy", 32'(bsy[i]), 32'd1);
                chk("done_early", 32'(dn[i]), 32'd0);
            end else begin
                chk("done", 32'(dn[i]), 32'd1);
                chk("busy_end", 32'(bsy[i]), 32'd0);
            end
        end
        @(negedge clk);
        chk("done_drop", 32'(dn[i]), 32'd0);
    endtask

    initial begin
        bit seen;
        checks = 0;
        errors = 0;
        flip   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            ab[i] = 1'b0;
        end
        rst = 1'b1;
        #12;
        chk_res(0, 1'b0, 6'd0, 5'd0, 1'b0);
        chk("rst_din", 32'(din[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_done", 32'(dn[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean sweep against a matching block.
        sweep(1, 0, 1'b0);
        chk_res(0, 1'b1, 6'd0, 5'd0, 1'b0);

        // Two injected faults.
        flip = 1'b1;
        sweep(1, 0, 1'b0);
        chk_res(0, 1'b0, 6'd2, 5'd7, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_mcnt", 32'(mc[0]), 32'd2);

        // Every vector fails.
        sweep(1, 1, 1'b0);
        chk_res(1, 1'b0, 6'd32, 5'd0, 1'b1);

        // S=3 with start hammered while busy.
        sweep(3, 2, 1'b1);
        chk_res(2, 1'b1, 6'd0, 5'd0, 1'b0);

        // Abort at cycle 10 after one mismatch has been recorded.
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            st[0] = 1'b0;
        end
        chk("pre_abort_mcnt", 32'(mc[0]), 32'd1);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_din", 32'(din[0]), 32'd0);
        chk_res(0, 1'b0, 6'd0, 5'd0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dn[0]) seen = 1'b1;
        end
        chk("abort_nodone", 32'(seen), 32'd0);
        flip = 1'b0;
        sweep(1, 0, 1'b0);
        chk_res(0, 1'b1, 6'd0, 5'd0, 1'b0);

        // Start and abort together in IDLE: start wins.
        @(negedge clk);
        st[0] = 1'b1;
        ab[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        ab[0] = 1'b0;
        chk("start_wins", 32'(bsy[0]), 32'd1);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("abort_idle", 32'(bsy[0]), 32'd0);

        // Asynchronous reset in cycle 15 of a faulty sweep.
        flip = 1'b1;
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            st[0] = 1'b0;
        end
        chk("pre_rst_mcnt", 32'(mc[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_din", 32'(din[0]), 32'd0);
        chk("arst_busy", 32'(bsy[0]), 32'd0);
        chk("arst_done", 32'(dn[0]), 32'd0);
        chk_res(0, 1'b0, 6'd0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        flip = 1'b0;
        sweep(1, 0, 1'b0);
        chk_res(0, 1'b1, 6'd0, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
